snake_head_ctrl: RTL and testbench

- Parametrised successor to the single-step ball mover: drives the head position of the player sprite for the game screen from keyboard keycodes.
- Adds several features: configurable bounds, step, size and move rate; latched direction requests with reversal rejection; selectable wall mode (bounce, wrap, stop); an explicit run-state FSM.
- The next position is always computed from the new direction within the same move tick, so there is no one-frame lag.
- Sits between the keyboard keycode source and the sprite/colour mapper, and feeds the body-segment logic via move_strobe.

---
 rtl/snake_pkg.sv | 39 +++
 rtl/move_tick_div.sv | 27 ++
 rtl/snake_head_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_snake_head_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types, constants and helpers for the snake head controller.
package snake_pkg;

  localparam int unsigned POS_W = 10;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DEAD   = 2'd3
  } state_t;

  localparam int unsigned WALL_BOUNCE = 0;
  localparam int unsigned WALL_WRAP   = 1;
  localparam int unsigned WALL_STOP   = 2;

  localparam logic [7:0] KEYCODE_UP    = 8'd26;
  localparam logic [7:0] KEYCODE_DOWN  = 8'd22;
  localparam logic [7:0] KEYCODE_LEFT  = 8'd4;
  localparam logic [7:0] KEYCODE_RIGHT = 8'd7;

  // Direction pointing the opposite way along the same axis.
  function automatic dir_t reverse_of(input dir_t d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction

endpackage

// File: rtl/move_tick_div.sv
// Free-running 0..DIV-1 counter; tick_c marks the enabled terminal-count cycle.
module move_tick_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = en && (cnt == LAST);

  // Count only while enabled; the value holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/snake_head_ctrl.sv
// Head position controller: keycode steering, move-rate divider, wall handling.
module snake_head_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned X_MIN     = 0,
  parameter int unsigned X_MAX     = 639,
  parameter int unsigned Y_MIN     = 0,
  parameter int unsigned Y_MAX     = 479,
  parameter int unsigned X_CENTER  = 320,
  parameter int unsigned Y_CENTER  = 240,
  parameter int unsigned STEP      = 4,
  parameter int unsigned SIZE      = 4,
  parameter int unsigned MOVE_DIV  = 4,
  parameter int unsigned WALL_MODE = 0,
  parameter logic [7:0]  KEY_UP    = KEYCODE_UP,
  parameter logic [7:0]  KEY_DOWN  = KEYCODE_DOWN,
  parameter logic [7:0]  KEY_LEFT  = KEYCODE_LEFT,
  parameter logic [7:0]  KEY_RIGHT = KEYCODE_RIGHT
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       pause,
  output logic [9:0] HeadX,
  output logic [9:0] HeadY,
  output logic [9:0] HeadS,
  output logic [1:0] dir,
  output logic       moving,
  output logic       move_strobe,
  output logic       hit_wall
);

  localparam int unsigned W  = POS_W;
  localparam int unsigned CW = POS_W + 2;

  localparam logic [CW-1:0] STEP_W  = CW'(STEP);
  localparam logic [CW-1:0] SIZE_W  = CW'(SIZE);
  localparam logic [CW-1:0] X_MIN_W = CW'(X_MIN);
  localparam logic [CW-1:0] X_MAX_W = CW'(X_MAX);
  localparam logic [CW-1:0] Y_MIN_W = CW'(Y_MIN);
  localparam logic [CW-1:0] Y_MAX_W = CW'(Y_MAX);

  if (!(SIZE < (X_MAX - X_MIN) / 2) || !(STEP <= SIZE * 2) || (MOVE_DIV < 1)) begin : g_param_check
    $error("snake_head_ctrl: illegal SIZE/STEP/MOVE_DIV parameters");
  end

  state_t         state, state_n;
  dir_t           dir_q, dir_n;
  dir_t           pend, pend_n;
  logic           pend_vld, pend_vld_n;
  logic [W-1:0]   x_n, y_n;
  logic           strobe_n;

  logic           key_vld, key_ok;
  dir_t           key_dir;
  dir_t           mv_dir;
  logic [CW-1:0]  step_xp, step_xm, step_yp, step_ym;
  logic           x_hi_hit, x_lo_hit, y_hi_hit, y_lo_hit, any_hit;
  logic           div_en, tick;

  assign HeadS  = W'(SIZE);
  assign dir    = dir_q;
  assign div_en = (state == RUN) && !pause;

  move_tick_div #(
    .DIV (MOVE_DIV)
  ) u_div (
    .clk    (frame_clk),
    .rst    (Reset),
    .en     (div_en),
    .tick_c (tick)
  );

  // Keycode to direction; a reverse of the current heading is not legal.
  always_comb begin
    key_vld = 1'b1;
    key_dir = RIGHT;
    if (keycode == KEY_UP)         key_dir = UP;
    else if (keycode == KEY_DOWN)  key_dir = DOWN;
    else if (keycode == KEY_LEFT)  key_dir = LEFT;
    else if (keycode == KEY_RIGHT) key_dir = RIGHT;
    else                           key_vld = 1'b0;
    key_ok = key_vld && (key_dir != reverse_of(dir_q));
  end

  // Move decision and wall detection; bounds compared before any subtract.
  always_comb begin
    mv_dir = dir_q;
    if (key_ok)        mv_dir = key_dir;
    else if (pend_vld) mv_dir = pend;
    step_xp  = (mv_dir == RIGHT) ? STEP_W : '0;
    step_xm  = (mv_dir == LEFT)  ? STEP_W : '0;
    step_yp  = (mv_dir == DOWN)  ? STEP_W : '0;
    step_ym  = (mv_dir == UP)    ? STEP_W : '0;
    x_hi_hit = (CW'(HeadX) + step_xp + SIZE_W) > (X_MAX_W + step_xm);
    x_lo_hit = (CW'(HeadX) + step_xp) < (X_MIN_W + SIZE_W + step_xm);
    y_hi_hit = (CW'(HeadY) + step_yp + SIZE_W) > (Y_MAX_W + step_ym);
    y_lo_hit = (CW'(HeadY) + step_yp) < (Y_MIN_W + SIZE_W + step_ym);
    any_hit  = x_hi_hit || x_lo_hit || y_hi_hit || y_lo_hit;
  end

  // Next state, key latch and position update.
  always_comb begin
    state_n    = state;
    dir_n      = dir_q;
    pend_n     = pend;
    pend_vld_n = pend_vld;
    x_n        = HeadX;
    y_n        = HeadY;
    strobe_n   = 1'b0;
    case (state)
      IDLE: begin
        if (key_vld) begin
          dir_n      = key_dir;
          pend_vld_n = 1'b0;
          state_n    = RUN;
        end
      end
      RUN: begin
        if (key_ok) begin
          pend_n     = key_dir;
          pend_vld_n = 1'b1;
        end
        if (pause) begin
          state_n = PAUSED;
        end else if (tick) begin
          dir_n      = mv_dir;
          pend_vld_n = 1'b0;
          if (!any_hit) begin
            x_n      = HeadX + W'(step_xp) - W'(step_xm);
            y_n      = HeadY + W'(step_yp) - W'(step_ym);
            strobe_n = 1'b1;
          end else if (WALL_MODE == WALL_BOUNCE) begin
            dir_n    = reverse_of(mv_dir);
            x_n      = HeadX - W'(step_xp) + W'(step_xm);
            y_n      = HeadY - W'(step_yp) + W'(step_ym);
            strobe_n = 1'b1;
          end else if (WALL_MODE == WALL_WRAP) begin
            if (x_hi_hit)      x_n = W'(X_MIN + SIZE);
            else if (x_lo_hit) x_n = W'(X_MAX - SIZE);
            if (y_hi_hit)      y_n = W'(Y_MIN + SIZE);
            else if (y_lo_hit) y_n = W'(Y_MAX - SIZE);
            strobe_n = 1'b1;
          end else begin
            state_n = DEAD;
          end
        end
      end
      PAUSED: begin
        if (key_ok) begin
          pend_n     = key_dir;
          pend_vld_n = 1'b1;
        end
        if (!pause) state_n = RUN;
      end
      default: ;
    endcase
  end

  // State and registered outputs; Reset overrides everything.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state       <= IDLE;
      dir_q       <= RIGHT;
      pend        <= RIGHT;
      pend_vld    <= 1'b0;
      HeadX       <= W'(X_CENTER);
      HeadY       <= W'(Y_CENTER);
      moving      <= 1'b0;
      move_strobe <= 1'b0;
      hit_wall    <= 1'b0;
    end else begin
      state       <= state_n;
      dir_q       <= dir_n;
      pend        <= pend_n;
      pend_vld    <= pend_vld_n;
      HeadX       <= x_n;
      HeadY       <= y_n;
      moving      <= (state_n == RUN);
      move_strobe <= strobe_n;
      hit_wall    <= (state_n == DEAD);
    end
  end

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Bench: bounce, wrap and stop instances against an integer reference model.
module tb_snake_head_ctrl;

  logic       frame_clk;
  logic       Reset;
  logic [7:0] keycode;
  logic       pause;

  logic [9:0] hx [3];
  logic [9:0] hy [3];
  logic [9:0] hs [3];
  logic [1:0] dr [3];
  logic       mv [3];
  logic       ms [3];
  logic       hw [3];

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state per instance (0=bounce, 1=wrap, 2=stop).
  int mx[3], my[3], md[3], mst[3], mpd[3], mcnt[3], mstb[3], mhit[3];
  int ycen[3] = '{240, 240, 239};

  snake_head_ctrl #(.WALL_MODE(0)) u_bounce (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .pause(pause),
    .HeadX(hx[0]), .HeadY(hy[0]), .HeadS(hs[0]), .dir(dr[0]),
    .moving(mv[0]), .move_strobe(ms[0]), .hit_wall(hw[0]));

  snake_head_ctrl #(.WALL_MODE(1)) u_wrap (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .pause(pause),
    .HeadX(hx[1]), .HeadY(hy[1]), .HeadS(hs[1]), .dir(dr[1]),
    .moving(mv[1]), .move_strobe(ms[1]), .hit_wall(hw[1]));

  snake_head_ctrl #(.WALL_MODE(2), .Y_CENTER(239)) u_stop (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .pause(pause),
    .HeadX(hx[2]), .HeadY(hy[2]), .HeadS(hs[2]), .dir(dr[2]),
    .moving(mv[2]), .move_strobe(ms[2]), .hit_wall(hw[2]));

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // -1 for keys that do not steer.
  function automatic int key2dir(input logic [7:0] k);
    case (k)
      8'd26:   return 0;
      8'd22:   return 1;
      8'd4:    return 2;
      8'd7:    return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int opposite(input int d);
    return (d < 2) ? 1 - d : 5 - d;
  endfunction

  task automatic model_move(input int k);
    int d, dx, dy, cx, cy;
    bit xhi, xlo, yhi, ylo;
    d = (mpd[k] >= 0) ? mpd[k] : md[k];
    md[k] = d;
    mpd[k] = -1;
    dx = (d == 3) ? 1 : (d == 2) ? -1 : 0;
    dy = (d == 1) ? 1 : (d == 0) ? -1 : 0;
    cx = mx[k] + dx * 4;
    cy = my[k] + dy * 4;
    xhi = (cx + 4 > 639);
    xlo = (cx < 4);
    yhi = (cy + 4 > 479);
    ylo = (cy < 4);
    if (!(xhi || xlo || yhi || ylo)) begin
      mx[k] = cx; my[k] = cy; mstb[k] = 1;
    end else if (k == 0) begin
      md[k] = opposite(d);
      mx[k] = mx[k] - dx * 4;
      my[k] = my[k] - dy * 4;
      mstb[k] = 1;
    end else if (k == 1) begin
      if (xhi) mx[k] = 4; else if (xlo) mx[k] = 635;
      if (yhi) my[k] = 4; else if (ylo) my[k] = 475;
      mstb[k] = 1;
    end else begin
      mst[k] = 3;
      mhit[k] = 1;
    end
  endtask

  // One frame of the behavioural model from the inputs sampled at this edge.
  task automatic model_step(input int k);
    int kd;
    kd = key2dir(keycode);
    mstb[k] = 0;
    if (Reset) begin
      mx[k] = 320; my[k] = ycen[k]; md[k] = 3; mst[k] = 0;
      mpd[k] = -1; mcnt[k] = 0; mhit[k] = 0;
    end else if (mst[k] == 0) begin
      if (kd >= 0) begin md[k] = kd; mst[k] = 1; mpd[k] = -1; end
    end else if (mst[k] != 3) begin
      if (kd >= 0 && kd != opposite(md[k])) mpd[k] = kd;
      if (mst[k] == 2) begin
        if (!pause) mst[k] = 1;
      end else if (pause) begin
        mst[k] = 2;
      end else if (mcnt[k] == 3) begin
        mcnt[k] = 0;
        model_move(k);
      end else begin
        mcnt[k]++;
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("x%0d", k),      int'(hx[k]), mx[k]);
      chk($sformatf("y%0d", k),      int'(hy[k]), my[k]);
      chk($sformatf("dir%0d", k),    int'(dr[k]), md[k]);
      chk($sformatf("moving%0d", k), int'(mv[k]), (mst[k] == 1) ? 1 : 0);
      chk($sformatf("strobe%0d", k), int'(ms[k]), mstb[k]);
      chk($sformatf("hit%0d", k),    int'(hw[k]), mhit[k]);
    end
  endtask

  task automatic cycle(input logic r, input logic [7:0] k, input logic p);
    @(negedge frame_clk);
    Reset = r; keycode = k; pause = p;
    @(posedge frame_clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    compare_all();
  endtask

  initial begin
    int strobes;
    logic p;
    logic [7:0] k;
    Reset = 1'b1; keycode = 8'd0; pause = 1'b0;

    // Reset state.
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    chk("rst_x", int'(hx[0]), 320);
    chk("rst_y", int'(hy[0]), 240);
    chk("rst_dir", int'(dr[0]), 3);
    chk("rst_moving", int'(mv[0]), 0);
    chk("rst_hit", int'(hw[0]), 0);
    chk("size", int'(hs[0]), 4);

    // First move four edges after the start key.
    cycle(0, 8'd7, 0);
    chk("start_moving", int'(mv[0]), 1);
    strobes = 0;
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 0, 0);
      strobes += int'(ms[0]);
      if (i == 3) chk("pre_tick_x", int'(hx[0]), 320);
    end
    chk("tick1_x", int'(hx[0]), 324);
    chk("tick1_y", int'(hy[0]), 240);

    // Reverse key ignored, later legal key used at the next tick.
    cycle(0, 8'd4, 0);
    cycle(0, 8'd26, 0);
    cycle(0, 0, 0);
    strobes += int'(ms[0]);
    cycle(0, 0, 0);
    strobes += int'(ms[0]);
    chk("turn_dir", int'(dr[0]), 0);
    chk("turn_y", int'(hy[0]), 236);
    chk("turn_x", int'(hx[0]), 324);
    chk("strobe_count", strobes, 2);

    // Right wall: bounce, wrap and stop responses.
    cycle(1, 0, 0);
    cycle(0, 8'd7, 0);
    for (int i = 1; i <= 316; i++) begin
      cycle(0, 0, 0);
      if (i == 312) chk("bounce_pre_x", int'(hx[0]), 632);
    end
    chk("bounce_x", int'(hx[0]), 628);
    chk("bounce_dir", int'(dr[0]), 2);
    chk("bounce_strobe", int'(ms[0]), 1);
    chk("wrapx_x", int'(hx[1]), 4);
    chk("stopx_hit", int'(hw[2]), 1);
    chk("stopx_x", int'(hx[2]), 632);

    // Top wall wrap.
    cycle(1, 0, 0);
    cycle(0, 8'd26, 0);
    for (int i = 1; i <= 240; i++) begin
      cycle(0, 0, 0);
      if (i == 236) chk("wrap_pre_y", int'(hy[1]), 4);
    end
    chk("wrap_y", int'(hy[1]), 475);
    chk("wrap_dir", int'(dr[1]), 0);
    chk("wrap_strobe", int'(ms[1]), 1);

    // Bottom wall stop, then keys have no effect.
    cycle(1, 0, 0);
    cycle(0, 8'd22, 0);
    for (int i = 1; i <= 240; i++) begin
      cycle(0, 0, 0);
      if (i == 236) chk("stop_pre_y", int'(hy[2]), 475);
    end
    chk("stop_hit", int'(hw[2]), 1);
    chk("stop_y", int'(hy[2]), 475);
    chk("stop_strobe", int'(ms[2]), 0);
    chk("stop_moving", int'(mv[2]), 0);
    for (int i = 0; i < 20; i++) begin
      cycle(0, 8'(key2dir(8'd0) + 1 + i % 26), 0);
      chk("dead_y", int'(hy[2]), 475);
      chk("dead_hit", int'(hw[2]), 1);
    end

    // Pause mid-run, then Reset mid-divider.
    cycle(1, 0, 0);
    cycle(0, 8'd7, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, (i == 4) ? 8'd26 : 8'd0, 1);
      chk("pause_x", int'(hx[0]), 324);
      chk("pause_moving", int'(mv[0]), 0);
    end
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("rst2_x", int'(hx[0]), 320);
    chk("rst2_y", int'(hy[0]), 240);
    chk("rst2_dir", int'(dr[0]), 3);
    chk("rst2_moving", int'(mv[0]), 0);

    // Randomized traffic against the model.
    p = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 11))
        0: k = 8'd26;
        1: k = 8'd22;
        2: k = 8'd4;
        3: k = 8'd7;
        4: k = 8'($urandom_range(0, 255));
        default: k = 8'd0;
      endcase
      if ($urandom_range(0, 15) == 0) p = ~p;
      cycle(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0, k, p);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
